// File: rtl/qif_spike_monitor.sv
// qif_spike_monitor: threshold spike detector with refractory period and windowed firing rate.
// Optional re-arm hysteresis (WAIT_LOW state) enabled by defining QIF_SPIKE_HYST_EN.
module qif_spike_monitor #(
    parameter logic [23:0] WINDOW_CYCLES  = 24'd10_000_000,
    parameter logic [7:0]  REFRACT_CYCLES = 8'd4
`ifdef QIF_SPIKE_HYST_EN
    ,
    parameter logic [7:0]  HYST_MARGIN    = 8'd16
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] v_mem,
    input  logic [7:0] v_thresh,
    output logic       spike,
    output logic       refractory,
    output logic [7:0] rate,
    output logic       rate_valid
);
`ifdef QIF_SPIKE_HYST_EN
    typedef enum logic [1:0] {ARMED, REFRACT, WAIT_LOW} state_t;
`else
    typedef enum logic [1:0] {ARMED, REFRACT} state_t;
`endif
    state_t      state, state_nx;
    logic [7:0]  rcnt, rcnt_nx;
    logic [23:0] win;
    logic [7:0]  scnt;
    logic        hit, fire, wrap;
    logic [8:0]  sum;
    logic [7:0]  sat;

    assign hit  = v_mem >= v_thresh;
    assign fire = (state == ARMED) && hit;
    assign wrap = win == WINDOW_CYCLES - 24'd1;
    // The pulse visible this cycle is counted before the window closes.
    assign sum  = {1'b0, scnt} + {8'b0, spike};
    assign sat  = sum[8] ? 8'hFF : sum[7:0];

`ifdef QIF_SPIKE_HYST_EN
    logic [7:0] rearm;
    assign rearm = (v_thresh > HYST_MARGIN) ? v_thresh - HYST_MARGIN : 8'd0;
`endif

    always_comb begin
        state_nx = state;
        rcnt_nx  = rcnt;
        if (state == ARMED) begin
            if (hit) begin
                state_nx = REFRACT;
                rcnt_nx  = REFRACT_CYCLES - 8'd1;
            end
        end else if (state == REFRACT) begin
            if (rcnt == 8'd0)
`ifdef QIF_SPIKE_HYST_EN
                state_nx = WAIT_LOW;
`else
                state_nx = ARMED;
`endif
            else
                rcnt_nx = rcnt - 8'd1;
        end
`ifdef QIF_SPIKE_HYST_EN
        else if (v_mem < rearm) begin
            state_nx = ARMED;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARMED;
            rcnt       <= 8'd0;
            win        <= 24'd0;
            scnt       <= 8'd0;
            spike      <= 1'b0;
            refractory <= 1'b0;
            rate       <= 8'd0;
            rate_valid <= 1'b0;
        end else begin
            spike      <= 1'b0;
            rate_valid <= 1'b0;
            if (ena) begin
                state      <= state_nx;
                rcnt       <= rcnt_nx;
                spike      <= fire;
                refractory <= state_nx == REFRACT;
                win        <= wrap ? 24'd0 : win + 24'd1;
                scnt       <= wrap ? 8'd0 : sat;
                rate_valid <= wrap;
                if (wrap)
                    rate <= sat;
            end
        end
    end
endmodule

// File: tb/tb_qif_spike_monitor.sv
// tb_qif_spike_monitor: vector table, corner sequences and randomized run against an event-level model.
module tb_qif_spike_monitor;
    localparam int W = 100;
    localparam int R = 4;

    logic       clk = 1'b0, rst_n = 1'b0, rst_nb = 1'b0, ena = 1'b0;
    logic [7:0] v_mem = 8'd0, v_thresh = 8'd0;
    logic       spike, refractory, rate_valid;
    logic [7:0] rate;
    logic       spike_b, refr_b, rv_b;
    logic [7:0] rate_b;

    always #5 clk = ~clk;

    qif_spike_monitor #(.WINDOW_CYCLES(24'd100), .REFRACT_CYCLES(8'd4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .v_mem(v_mem), .v_thresh(v_thresh),
        .spike(spike), .refractory(refractory), .rate(rate), .rate_valid(rate_valid));

    qif_spike_monitor #(.WINDOW_CYCLES(24'd2000), .REFRACT_CYCLES(8'd1)) dut_b (
        .clk(clk), .rst_n(rst_nb), .ena(1'b1), .v_mem(v_mem), .v_thresh(8'd0),
        .spike(spike_b), .refractory(refr_b), .rate(rate_b), .rate_valid(rv_b));

    int checks = 0, errors = 0;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", n, a, e);
        end
    endtask

    // Model: fire allowed when more than R enabled cycles have passed since the last fire.
    int t, last, cnt, m_rate;
    bit has_last, m_spike, m_refr, m_valid;

    task automatic m_reset();
        t = 0; last = 0; has_last = 0; cnt = 0;
        m_rate = 0; m_spike = 0; m_refr = 0; m_valid = 0;
    endtask

    task automatic m_edge(input bit e, input int vm, input int th);
        bit f;
        int s;
        if (!e) begin
            m_spike = 0;
            m_valid = 0;
            return;
        end
        f = (vm >= th) && (!has_last || (t - last) >= R + 1);
        if (f) begin
            last = t;
            has_last = 1;
        end
        m_refr = has_last && (t - last) < R;
        s = cnt + int'(m_spike);
        if (s > 255) s = 255;
        if (t % W == W - 1) begin
            m_rate = s; cnt = 0; m_valid = 1;
        end else begin
            cnt = s; m_valid = 0;
        end
        m_spike = f;
        t++;
    endtask

    task automatic tick(input bit e, input int vm, input int th);
        ena = e; v_mem = 8'(vm); v_thresh = 8'(th);
        @(posedge clk);
        m_edge(e, vm, th);
        #1;
        chk("spike", int'(spike), int'(m_spike));
        chk("refractory", int'(refractory), int'(m_refr));
        chk("rate", int'(rate), m_rate);
        chk("rate_valid", int'(rate_valid), int'(m_valid));
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        chk("rst_spike", int'(spike), 0);
        chk("rst_refr", int'(refractory), 0);
        chk("rst_rate", int'(rate), 0);
        chk("rst_valid", int'(rate_valid), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        bit e;
        int vm;
        int th;
        bit sp;
        bit rf;
    } vec_t;
    vec_t tbl[12];

    initial begin
        int ns, first;
        for (int k = 0; k < 12; k++)
            tbl[k] = '{1'b1, (k == 0) ? 50 : 120, 100, k % 5 == 1, k % 5 != 0};
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int k = 0; k < 12; k++) begin
            tick(tbl[k].e, tbl[k].vm, tbl[k].th);
            chk($sformatf("tbl%0d_spike", k), int'(spike), int'(tbl[k].sp));
            chk($sformatf("tbl%0d_refr", k), int'(refractory), int'(tbl[k].rf));
        end

        // Asynchronous reset while refractory is high, no clock edge involved.
        #3 rst_n = 1'b0;
        m_reset();
        #1;
        chk("async_refr", int'(refractory), 0);
        chk("async_spike", int'(spike), 0);
        chk("async_valid", int'(rate_valid), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1, 120, 100);
        chk("post_reset_fire", int'(spike), 1);

        do_reset();
        ns = 0;
        for (int i = 0; i < 250; i++) begin
            tick(1, 120, 100);
            if (rate_valid) begin
                ns++;
                if (ns == 1) chk("first_strobe_edge", i, 99);
                chk("window_rate", int'(rate), 20);
            end
        end
        chk("strobe_count", ns, 2);

        do_reset();
        tick(1, 120, 100);
        tick(1, 120, 100);
        for (int i = 0; i < 10; i++) begin
            tick(0, 120, 100);
            chk("hold_refr", int'(refractory), 1);
            chk("hold_spike", int'(spike), 0);
            chk("hold_valid", int'(rate_valid), 0);
        end
        first = -1;
        for (int i = 12; i < 150; i++) begin
            tick(1, 120, 100);
            if (rate_valid && first < 0) first = i;
        end
        chk("delayed_strobe_edge", first, 109);

        tick(1, 254, 255);
        chk("thr_ff_low", int'(spike), 0);
        do_reset();
        tick(1, 255, 255);
        chk("thr_ff_fire", int'(spike), 1);

        do_reset();
        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 7) != 0, $urandom_range(0, 255),
                 ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(60, 200));

        #2 rst_nb = 1'b1;
        for (int i = 0; i < 2100; i++) begin
            @(posedge clk);
            #1;
            if (rv_b) break;
        end
        chk("sat_strobe_seen", int'(rv_b), 1);
        chk("sat_rate", int'(rate_b), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/qif_spike_monitor.md
Name: qif_spike_monitor

Overview:
- Downstream stage of the QIF neuron: consumes the 8-bit membrane value V_mem each clock and detects threshold crossings.
- On a crossing it emits a one-cycle spike pulse, then enforces a refractory period.
- Counts spikes over a fixed time window and publishes a saturating 8-bit firing rate with a one-cycle valid strobe.
- Output feeds the top-level uo_out/uio_out muxing and the on-board spike LED.

Parameters:
- WINDOW_CYCLES, 24'd10_000_000, rate window length in clk cycles; legal range 2..2^24-1.
- REFRACT_CYCLES, 8'd4, refractory length in clk cycles; legal range 1..255.
- HYST_MARGIN, 8'd16, re-arm margin below threshold; used only with the optional feature.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- ena  input  1  design enable; low freezes all state
- v_mem  input  8  membrane value from neuron, unsigned
- v_thresh  input  8  spike threshold, unsigned, sampled every cycle
- spike  output  1  one-cycle spike pulse, registered
- refractory  output  1  high while in refractory period
- rate  output  8  spike count of last completed window, saturating
- rate_valid  output  1  one-cycle strobe when rate updates

Behaviour:
- Reset (async, rst_n low):
  - Outputs: spike=0, refractory=0, rate=0, rate_valid=0.
  - State ARMED; refract counter, window counter and spike counter all 0.
- Reset mid-operation aborts any refractory period and discards the partial window count.
- Detection compare: unsigned v_mem >= v_thresh.
- FSM states: ARMED, REFRACT (plus WAIT_LOW with the optional feature).
- ARMED:
  - If ena and compare true in cycle N: spike=1 and refractory=1 in cycle N+1 (one-cycle latency).
  - Refract counter loads REFRACT_CYCLES-1; state moves to REFRACT.
- REFRACT:
  - refractory=1; spike=0; crossings ignored.
  - Counter decrements each enabled cycle.
  - At counter 0 the state returns to ARMED; refractory is low in the following cycle.
  - Total refractory high time is exactly REFRACT_CYCLES cycles.
  - Back in ARMED, a compare that is still true fires again immediately (tonic firing). With a held supra-threshold input, the spike period is REFRACT_CYCLES+1 cycles.
- Spike pulse is never longer than 1 cycle.
- Window counter:
  - Increments each enabled cycle 0..WINDOW_CYCLES-1, then wraps to 0.
  - On the wrap cycle: rate <= spike counter, including any spike pulse asserted in that same cycle, saturated at 8'hFF. rate_valid=1 for exactly that one cycle. Spike counter clears to 0.
  - Spike counter increments on each spike pulse and holds at 8'hFF; it never wraps.
- rate holds its value between strobes.
- ena low:
  - FSM, refract counter, window counter and spike counter all hold.
  - spike and rate_valid are driven 0; refractory keeps its value.
  - On ena re-assertion, operation resumes from the held state.
- v_thresh=0: compare is always true, so the block fires at maximum tonic rate.
- v_thresh=8'hFF: fires only at v_mem=8'hFF.

Optional Feature:
- Macro: QIF_SPIKE_HYST_EN.
- Defined:
  - After REFRACT expires, the FSM enters WAIT_LOW instead of ARMED.
  - It moves to ARMED only when v_mem < v_thresh - HYST_MARGIN. This subtraction saturates at 0, so with v_thresh <= HYST_MARGIN, re-arming requires v_mem < 0 and the block never re-arms until reset.
  - refractory=0 in WAIT_LOW.
  - A held supra-threshold input yields exactly one spike.
- Undefined: no WAIT_LOW state, tonic behaviour as above, HYST_MARGIN unused.

Test Plan:
- Reset with rst_n low asynchronously mid-REFRACT -> all outputs 0 immediately, no clock edge needed; after release the first crossing fires normally.
- v_thresh=100; v_mem steps 50->120 in cycle N, stays 120; REFRACT_CYCLES=4 -> spike at N+1, N+6, N+11...; refractory high N+1..N+4, N+6..N+9.
- WINDOW_CYCLES=100, REFRACT_CYCLES=4, held supra-threshold -> rate_valid every 100 cycles; first rate=20; steady-state rate=20±1 per window.
- WINDOW_CYCLES=2000, REFRACT_CYCLES=1, v_thresh=0 -> rate=8'hFF (saturated), not wrapped.
- ena dropped for 10 cycles mid-REFRACT -> refractory stays high; no spike or strobe; window boundary delayed by exactly 10 cycles.
- With QIF_SPIKE_HYST_EN, v_thresh=100, HYST_MARGIN=16: hold v_mem=120 -> one spike only; drop to 90 -> no re-arm; drop to 83 -> ARMED; back to 120 -> second spike.
